// File: rtl/switch_reader_pkg.sv
// Shared defaults and helpers for the switch debouncer.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
// Contents: DEF_TICK_DIV, DEF_STABLE_TICKS, DEF_WIDTH, span_w().
package switch_reader_pkg;

  localparam int DEF_TICK_DIV     = 100000;  // 1 ms sample tick at 100 MHz
  localparam int DEF_STABLE_TICKS = 10;
  localparam int DEF_WIDTH        = 16;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int span_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_reader_debounce_bit.sv
// Per-switch debouncer: 2-flop synchronizer, stability counter, level and edge pulses.
// Latency: 2 sync cycles + STABLE_TICKS mismatching ticks + 1 cycle to accept.
// Backpressure: none; free-running, accepts a new level whenever it is stable.
// Ports: clk_i/rst_ni clock and async active-low reset; tick_i shared sample strobe;
//        sw_i raw pin; sw_o debounced level; rise_o/fall_o one-cycle edge pulses;
//        accept_o combinational "level accepted on the next edge" for the change summary.
module debounce_bit
  import switch_reader_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam int            CW   = span_w(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          meta_q, sync_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mismatch, accept;

  always_comb begin
    mismatch = sync_q ^ lvl_q;
    accept   = mismatch & tick_i & (cnt_q == LAST);
    cnt_d    = cnt_q;
    // Any cycle of agreement (a bounce back) throws away the partial count;
    // acceptance also restarts it. The counter tops out at LAST, so it never wraps.
    if (!mismatch || accept) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
    lvl_d  = accept ? sync_q : lvl_q;
    rise_d = accept &  sync_q;
    fall_d = accept & ~sync_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sw_o     = lvl_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign accept_o = accept;

endmodule

// File: rtl/switch_reader.sv
// Debounces WIDTH board switches against a shared sample tick and reports level edges.
// Latency: between (STABLE_TICKS-1)*TICK_DIV+4 and STABLE_TICKS*TICK_DIV+3 cycles per step.
// Backpressure: none; outputs are registered status/pulses with no handshake.
// Ports: CLK, RST_N (async active-low); SW_I raw pins; SW_O debounced levels;
//        SW_RISE/SW_FALL per-bit one-cycle edge pulses; SW_CHG any-edge pulse.
module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int WIDTH        = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW_I,
  output logic [WIDTH-1:0] SW_O,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_CHG
);

  localparam int            TW        = span_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] accept;

  // With TICK_DIV=1 the counter is pinned at 0 == TICK_LAST, so tick is constant high.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    // Built from next-state accepts so SW_CHG lines up with the registered pulses.
    chg_d      = |accept;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt_q <= '0;
      chg_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      chg_q      <= chg_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .tick_i  (tick),
      .sw_i    (SW_I[g]),
      .sw_o    (SW_O[g]),
      .rise_o  (SW_RISE[g]),
      .fall_o  (SW_FALL[g]),
      .accept_o(accept[g])
    );
  end

  assign SW_CHG = chg_q;

endmodule
